// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 32 x XLEN integer register file plus pending-write scoreboard.
// Optional macro RF_BYPASS_EN: same-cycle WriteBack forwarding onto the read ports.
//
// Ports:
//   clk, rst (async, active-low)
//   RegWriteW, RdW, ResultW   : WriteBack write port
//   Rs1D, Rs2D -> RD1D, RD2D  : combinational Decode reads
//   Busy1D, Busy2D            : source operand has an outstanding write
//   IssueD, RdD               : mark destination pending at issue
//   KillE, RdE                : clear pending mark of a squashed instruction
//   RetireCount               : committed writes to x1..x31 (wraps)
module regfile_scoreboard #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    output logic [XLEN-1:0] RD1D,
    output logic [XLEN-1:0] RD2D,
    output logic            Busy1D,
    output logic            Busy2D,
    input  logic            IssueD,
    input  logic [4:0]      RdD,
    input  logic            KillE,
    input  logic [4:0]      RdE,
    output logic [XLEN-1:0] RetireCount
);

    logic [XLEN-1:0] regs [32];
    logic [31:0]     pending;
    logic [31:0]     pending_nxt;
    logic [31:0]     set_vec;
    logic [31:0]     clr_vec;
    logic [XLEN-1:0] retire_cnt;
    logic            wr_en;
    logic            hit1;
    logic            hit2;
    logic [XLEN-1:0] stored1;
    logic [XLEN-1:0] stored2;

    assign wr_en = RegWriteW && (RdW != 5'd0);

    // A set from a newly issuing instruction overrides any clear on the same
    // register, since the newer instruction now owns it. Bit 0 never sets.
    always_comb begin
        set_vec = 32'd0;
        clr_vec = 32'd0;
        if (IssueD) set_vec[RdD] = 1'b1;
        if (RegWriteW) clr_vec[RdW] = 1'b1;
        if (KillE) clr_vec[RdE] = 1'b1;
        pending_nxt = (set_vec | (pending & ~clr_vec)) & ~32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            pending    <= 32'd0;
            retire_cnt <= '0;
        end else begin
            if (wr_en) begin
                regs[RdW]  <= ResultW;
                retire_cnt <= retire_cnt + XLEN'(1);
            end
            pending <= pending_nxt;
        end
    end

    assign stored1 = (Rs1D == 5'd0) ? '0 : regs[Rs1D];
    assign stored2 = (Rs2D == 5'd0) ? '0 : regs[Rs2D];

`ifdef RF_BYPASS_EN
    assign hit1 = wr_en && (RdW == Rs1D);
    assign hit2 = wr_en && (RdW == Rs2D);
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    assign RD1D = hit1 ? ResultW : stored1;
    assign RD2D = hit2 ? ResultW : stored2;

    assign Busy1D = pending[Rs1D] && !hit1;
    assign Busy2D = pending[Rs2D] && !hit2;

    assign RetireCount = retire_cnt;

endmodule
